// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler: queues resolved branches and
// shares the single predictor port between fetch lookups and updates.
module bp_update_scheduler #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       resolve_valid,
   output logic                       resolve_ready,
   input  logic [31:0]                resolve_pc,
   input  logic                       resolve_taken,
   input  logic                       resolve_mispred,
   input  logic                       lookup_req,
   output logic                       lookup_stall,
   output logic                       upd_ld,
   output logic [31:0]                upd_pc,
   output logic                       upd_br_en,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   input  logic                       clr_stats,
   output logic [31:0]                br_total,
   output logic [31:0]                mispred_total
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   logic [31:0]    pc_mem [DEPTH];
   logic [DEPTH-1:0] tk_mem;
   logic [AW-1:0]  head;
   logic [AW-1:0]  tail;
   logic [OW-1:0]  occ;
   logic [7:0]     age;
   logic           full;
   logic           empty;
   logic           force_upd;
   logic           enq;
   logic           deq;

   assign full      = (occ == OW'(DEPTH));
   assign empty     = (occ == '0);
   assign force_upd = full || (age >= 8'(STARVE_LIMIT));

   // Port arbitration: updates win when fetch is idle or head must go.
   assign resolve_ready = rst && !full;
   assign upd_ld        = rst && !empty && (!lookup_req || force_upd);
   assign lookup_stall  = lookup_req && upd_ld;
   assign enq           = resolve_valid && resolve_ready;
   assign deq           = upd_ld;

   assign upd_pc    = pc_mem[head];
   assign upd_br_en = tk_mem[head];
   assign occupancy = occ;

   // Entry storage; contents need no reset since occupancy guards them.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[tail] <= resolve_pc;
         tk_mem[tail] <= resolve_taken;
      end
   end

   // Pointers and occupancy; power-of-two depth wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         unique case ({enq, deq})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Head wait counter, saturating at the starvation threshold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         age <= '0;
      end else if (deq || empty) begin
         age <= '0;
      end else if (age < 8'(STARVE_LIMIT)) begin
         age <= age + 8'd1;
      end
   end

   // Saturating statistics; clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_total      <= '0;
         mispred_total <= '0;
      end else if (clr_stats) begin
         br_total      <= '0;
         mispred_total <= '0;
      end else if (enq) begin
         if (br_total != 32'hFFFF_FFFF)
            br_total <= br_total + 32'd1;
         if (resolve_mispred && mispred_total != 32'hFFFF_FFFF)
            mispred_total <= mispred_total + 32'd1;
      end
   end

endmodule

// File: doc/bp_update_scheduler.md
BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-update FIFO entries (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 8, cycles the head entry may wait before it preempts lookups (1..255).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 resolve_valid  input  1  EX stage presents a resolved conditional branch.
REQ-006 resolve_ready  output  1  scheduler accepts the resolution this cycle.
REQ-007 resolve_pc  input  32  PC of resolved branch.
REQ-008 resolve_taken  input  1  actual branch outcome.
REQ-009 resolve_mispred  input  1  fetch-time prediction differed from outcome.
REQ-010 lookup_req  input  1  fetch needs the predictor port for a lookup this cycle.
REQ-011 lookup_stall  output  1  fetch lookup denied this cycle, fetch must retry.
REQ-012 upd_ld  output  1  update strobe to predictor (drives pred_ld).
REQ-013 upd_pc  output  32  PC for update (drives predictor pc while upd_ld=1).
REQ-014 upd_br_en  output  1  outcome for update (drives cpu_br_en).
REQ-015 occupancy  output  $clog2(DEPTH+1)  entries currently queued.
REQ-016 clr_stats  input  1  synchronous clear of statistic counters.
REQ-017 br_total  output  32  resolved branches accepted since reset/clear.
REQ-018 mispred_total  output  32  accepted branches flagged mispredicted.

Function
REQ-019 Enqueue SHALL occur when resolve_valid && resolve_ready; entry = {resolve_pc, resolve_taken}, stored at tail, tail pointer wraps modulo DEPTH.
REQ-020 resolve_ready SHALL equal (occupancy < DEPTH); no same-cycle bypass, so a full queue stays not-ready even while dequeuing.
REQ-021 force SHALL be asserted when occupancy == DEPTH or age >= STARVE_LIMIT.
REQ-022 upd_ld SHALL be combinational: (occupancy > 0) && (!lookup_req || force).
REQ-023 upd_pc/upd_br_en SHALL always reflect the head entry; value irrelevant when occupancy == 0.
REQ-024 lookup_stall SHALL equal lookup_req && upd_ld.
REQ-025 Dequeue SHALL occur on every cycle upd_ld = 1; head pointer wraps modulo DEPTH.
REQ-026 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged and preserve FIFO order.
REQ-027 Empty queue with resolve_valid: entry is written, upd_ld first asserts the following cycle (latency 1 minimum).
REQ-028 age counter (8 bits): cleared on dequeue or when occupancy == 0; else increments each cycle head waits, saturating at STARVE_LIMIT.
REQ-029 Starvation cap: a queued head entry SHALL be issued within STARVE_LIMIT+1 cycles of reaching head regardless of lookup_req.
REQ-030 On enqueue, br_total SHALL increment, and mispred_total SHALL increment if resolve_mispred; both saturate at 32'hFFFF_FFFF.
REQ-031 clr_stats SHALL zero both counters next edge and take priority over a same-cycle enqueue increment (that branch not counted); the queue itself is unaffected.
REQ-032 No flush input: resolved branches are architectural and are never discarded.

Reset
REQ-033 rst low SHALL immediately clear head, tail, occupancy, age, br_total, mispred_total to 0.
REQ-034 While rst low: upd_ld = 0, lookup_stall = 0, resolve_ready = 0; queue entries lost on mid-operation reset.
REQ-035 First edge after rst deasserts SHALL accept enqueue (resolve_ready = 1).

Verification
REQ-036 Idle port: lookup_req=0, enqueue PC 0x100 taken -> next cycle upd_ld=1, upd_pc=0x100, upd_br_en=1, occupancy 1->0.
REQ-037 Fill: lookup_req=1 held, enqueue 4 entries on consecutive cycles -> occupancy=4, resolve_ready=0, upd_ld=1 and lookup_stall=1 same cycle, first issued PC is first enqueued.
REQ-038 Starvation: lookup_req=1 held, one entry queued -> upd_ld asserts exactly 8 cycles after entry reaches head, lookup_stall=1 that cycle, age returns 0.
REQ-039 Concurrent: occupancy=2, enqueue with upd_ld=1 same cycle -> occupancy stays 2, issue order matches enqueue order across pointer wrap.
REQ-040 Stats: accept 5 branches, 2 with resolve_mispred -> br_total=5, mispred_total=2; clr_stats with simultaneous mispredicted enqueue -> both 0 next cycle, entry still queued.
REQ-041 Reset mid-operation: occupancy=3, drive rst low asynchronously between edges -> upd_ld, occupancy, counters 0 before next clock edge; after release, resolve_ready=1.
